cascade_counter: RTL

- Parametrised multi-digit successor to the single-digit base-N counter.
- Chains NUM_DIGITS digits, each with its own base, into one up/down counter with a run/stop/expired state machine, parallel load, saturating countdown option and terminal/carry flags.
- Sits between the tick prescaler and the 7-segment display mux of the stopwatch.
- Default configuration is MM:SS.

---
 rtl/counter_pkg.sv | 10 +
 rtl/digit_cell.sv | 24 ++
 rtl/cascade_counter.sv | 88 ++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared state encoding and base-field constants for cascade_counter.
package counter_pkg;
  typedef enum logic [1:0] {
    STOPPED = 2'b00,
    RUNNING = 2'b01,
    EXPIRED = 2'b10
  } state_t;
  localparam int BASE_FIELD_W = 8;
  localparam logic [31:0] MMSS_BASES = 32'h06_0A_06_0A;
endpackage

// File: rtl/digit_cell.sv
// digit_cell: one base-BASE digit with clamped parallel load and up/down step.
module digit_cell #(
  parameter int BASE = 10,
  parameter int DIGIT_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [DIGIT_BITS-1:0] load_value,
  output logic [DIGIT_BITS-1:0] digit,
  output logic                  at_terminal
);
  localparam logic [DIGIT_BITS-1:0] MAX = DIGIT_BITS'(BASE - 1);
  logic [DIGIT_BITS-1:0] nxt;
  assign at_terminal = up_down ? digit == MAX : digit == '0;
  assign nxt = up_down ? (digit == MAX ? '0 : digit + 1'b1) : (digit == '0 ? MAX : digit - 1'b1);
  always_ff @(posedge clk) begin
    if (!rst) digit <= '0;
    else if (load) digit <= load_value > MAX ? MAX : load_value;
    else if (step) digit <= nxt;
  end
endmodule

// File: rtl/cascade_counter.sv
// cascade_counter: chained mixed-radix up/down counter with run/stop/expire FSM.
// Optional lap capture port set enabled by CASCADE_COUNTER_LAP_CAPTURE_EN.
module cascade_counter
  import counter_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_BITS = 4,
  parameter logic [BASE_FIELD_W*NUM_DIGITS-1:0] BASES = (BASE_FIELD_W*NUM_DIGITS)'(MMSS_BASES),
  parameter bit STOP_AT_ZERO = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tick,
  input  logic                             up_down,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             load,
  input  logic [NUM_DIGITS*DIGIT_BITS-1:0] load_value,
  output logic [NUM_DIGITS*DIGIT_BITS-1:0] digits,
  output logic                             running,
  output logic                             expired,
  output logic                             terminal,
  output logic                             carry_out
`ifdef CASCADE_COUNTER_LAP_CAPTURE_EN
  ,
  input  logic                             lap,
  output logic [NUM_DIGITS*DIGIT_BITS-1:0] lap_digits,
  output logic                             lap_valid
`endif
);
  state_t state, state_n;
  logic [NUM_DIGITS-1:0] term, low_term;
  logic honour, hold, carry_n;
  assign terminal = &term;
  assign honour = state == RUNNING && tick && !load && !stop;
  // a down-count from all-zero freezes the digits instead of wrapping
  assign hold = terminal && !up_down && STOP_AT_ZERO;
  assign carry_n = honour && terminal && !hold;
  assign running = state == RUNNING;
  assign expired = state == EXPIRED;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign low_term[i] = 1'b1;
    end else begin : g_upper
      assign low_term[i] = &term[i-1:0];
    end
    digit_cell #(
      .BASE(int'(BASES[BASE_FIELD_W*i +: BASE_FIELD_W])),
      .DIGIT_BITS(DIGIT_BITS)
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .step(honour && !hold && low_term[i]),
      .up_down(up_down),
      .load(load),
      .load_value(load_value[DIGIT_BITS*i +: DIGIT_BITS]),
      .digit(digits[DIGIT_BITS*i +: DIGIT_BITS]),
      .at_terminal(term[i])
    );
  end
  always_comb begin
    state_n = state;
    if (load) state_n = STOPPED;
    else if (stop) state_n = state == RUNNING ? STOPPED : state;
    else if (start && state == STOPPED) state_n = RUNNING;
    else if (honour && hold) state_n = EXPIRED;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= STOPPED;
      carry_out <= 1'b0;
    end else begin
      state <= state_n;
      carry_out <= carry_n;
    end
  end
`ifdef CASCADE_COUNTER_LAP_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      lap_digits <= '0;
      lap_valid <= 1'b0;
    end else begin
      if (lap) lap_digits <= digits;
      lap_valid <= lap || (lap_valid && !load);
    end
  end
`endif
endmodule
